// File: rtl/serializer_pkg.sv
// serializer_pkg
// Shared types for the serializer: the complex sample type carried on the
// streaming datapath, the serializer FSM state encoding, and a helper giving
// the number of output pairs in a frame.
package serializer_pkg;

  localparam int SER_DATA_W = 16;

  // One complex sample: signed real and imaginary parts.
  typedef struct packed {
    logic signed [SER_DATA_W-1:0] re;
    logic signed [SER_DATA_W-1:0] im;
  } complex_product_t;

  // IDLE: waiting for a frame; SEND: streaming pairs of the held frame.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // A frame of n samples leaves the serializer as n/2 pairs.
  function automatic int ser_pairs(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/serializer.sv
// serializer
// Parallel-to-serial converter: takes one frame of N complex samples through
// a valid/ready handshake and emits it as N/2 pairs on x_0/x_1, highest index
// first: (frame[N-1], frame[N-2]) ... (frame[1], frame[0]). That order lets
// the pair-wise deserializer rebuild the original frame.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   enable     synchronous run control; low flushes the block
//   x_parallel input frame (N samples)
//   in_valid   x_parallel holds a frame
//   in_ready   block can accept a frame this cycle (combinational in out_ready)
//   x_0, x_1   current pair, forced to zero when no pair is valid
//   out_valid  x_0/x_1 hold a valid pair
//   out_ready  downstream takes the pair this cycle
//   out_last   current pair is the final pair of the frame
module serializer
  import serializer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  complex_product_t [N-1:0]     x_parallel,
  input  logic                         in_valid,
  output logic                         in_ready,
  output complex_product_t             x_0,
  output complex_product_t             x_1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);

  localparam int PTR_W = $clog2(N);
  localparam logic [PTR_W-1:0] PTR_START = PTR_W'(N - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_STEP  = PTR_W'(2);

  ser_state_t                 state_q, state_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  complex_product_t [N-1:0]   frame_q, frame_d;
  logic [PTR_W-1:0]           rd_ptr_lo;
  logic                       accept;

  // rd_ptr always points at the odd (upper) sample of the current pair, so
  // the lower sample is simply rd_ptr-1 and the final pair is rd_ptr == 1.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    frame_d   = frame_q;
    rd_ptr_lo = rd_ptr_q - PTR_W'(1);

    out_valid = (state_q == SEND);
    out_last  = out_valid & (rd_ptr_q == PTR_LAST);
    // Accepting during the last pair's handshake keeps frames back-to-back.
    in_ready  = reset_n & enable & ((state_q == IDLE) | (out_last & out_ready));
    accept    = in_valid & in_ready;

    x_0 = '0;
    x_1 = '0;
    if (out_valid) begin
      x_0 = frame_q[rd_ptr_q];
      x_1 = frame_q[rd_ptr_lo];
    end

    if (!enable) begin
      // Flush wins over everything: any frame in flight is dropped.
      state_d  = IDLE;
      rd_ptr_d = PTR_START;
      frame_d  = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (out_last) begin
          state_d = IDLE;
        end else begin
          rd_ptr_d = rd_ptr_q - PTR_STEP;
        end
      end
      // A new frame overrides the end-of-frame return to IDLE.
      if (accept) begin
        frame_d  = x_parallel;
        rd_ptr_d = PTR_START;
        state_d  = SEND;
      end
    end
  end

  // State, pointer and frame buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= PTR_START;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      frame_q  <= frame_d;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// tb_serializer
// Scoreboard bench for the serializer. Each accepted frame is expanded into
// its expected pairs and queued; a monitor on the falling edge compares what
// the DUT presents against the head of the queue and pops on handshake.
module tb_serializer;
  import serializer_pkg::*;

  localparam int N     = 8;
  localparam int PAIRS = ser_pairs(N);

  typedef complex_product_t [N-1:0] frame_t;

  typedef struct packed {
    complex_product_t a;
    complex_product_t b;
    logic             last;
  } pair_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  frame_t           x_parallel;
  logic             in_valid;
  logic             in_ready;
  complex_product_t x_0;
  complex_product_t x_1;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  pair_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  serializer #(.N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .x_parallel (x_parallel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_0        (x_0),
    .x_1        (x_1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  // One comparison; reports and counts a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic frame_t ramp(input int base);
    frame_t r;
    for (int i = 0; i < N; i++) begin
      r[i].re = 16'(base + i);
      r[i].im = 16'(-(base + i));
    end
    return r;
  endfunction

  function automatic frame_t random_frame();
    frame_t r;
    for (int i = 0; i < N; i++) r[i] = complex_product_t'($urandom);
    return r;
  endfunction

  // Drive one cycle of inputs, then decide what the coming edge does to the
  // expected stream: a flush drops everything, an accept queues a new frame.
  task automatic applyStimulus(input logic v, input frame_t f, input logic rdy,
                               input logic en, output logic accepted);
    @(posedge clk);
    #1;
    in_valid   = v;
    x_parallel = f;
    out_ready  = rdy;
    enable     = en;
    #6;
    accepted = in_valid & in_ready;
    if (!enable) exp_q.delete();
    if (accepted) begin
      for (int k = 0; k < PAIRS; k++) begin
        pair_t p;
        p.a    = f[N-1-2*k];
        p.b    = f[N-2-2*k];
        p.last = (k == PAIRS - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  // Hold in_valid until the frame is taken; returns the cycles spent.
  task automatic sendFrame(input frame_t f, output int tries);
    logic acc;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 40) begin
      applyStimulus(1'b1, f, 1'b1, 1'b1, acc);
      tries++;
    end
    if (!acc) checkOutput("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, rdy, 1'b1, acc);
  endtask

  // Monitor: with the expected stream as the only reference, the DUT must
  // show a pair exactly when one is outstanding, and be ready exactly when
  // nothing would be left after this cycle.
  always @(negedge clk) begin
    pair_t e;
    logic  has;
    has = (exp_q.size() > 0);
    checkOutput("out_valid", 32'(out_valid), 32'(has));
    checkOutput("in_ready", 32'(in_ready),
                32'(reset_n & enable & (!has | ((exp_q.size() == 1) & out_ready))));
    if (has) begin
      e = exp_q[0];
      checkOutput("x_0", 32'(x_0), 32'(e.a));
      checkOutput("x_1", 32'(x_1), 32'(e.b));
      checkOutput("out_last", 32'(out_last), 32'(e.last));
      if (out_ready) void'(exp_q.pop_front());
    end else begin
      checkOutput("x_0_idle", 32'(x_0), 32'(0));
      checkOutput("x_1_idle", 32'(x_1), 32'(0));
      checkOutput("out_last_idle", 32'(out_last), 32'(0));
    end
  end

  initial begin
    logic acc;
    int   tries;

    reset_n    = 1'b1;
    enable     = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    x_parallel = '0;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_out_last", 32'(out_last), 32'(0));
    checkOutput("rst_x_0", 32'(x_0), 32'(0));
    checkOutput("rst_x_1", 32'(x_1), 32'(0));
    checkOutput("rst_in_ready", 32'(in_ready), 32'(0));
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    idleCycles(2, 1'b1);

    $display("[TB] basic frame");
    sendFrame(ramp(0), tries);
    idleCycles(6, 1'b1);

    $display("[TB] back-to-back frames");
    sendFrame(ramp(0), tries);
    sendFrame(ramp(100), tries);
    checkOutput("b2b_accept_cycle", 32'(tries), 32'(PAIRS));
    idleCycles(6, 1'b1);

    $display("[TB] backpressure");
    sendFrame(ramp(20), tries);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, acc);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1, acc);
    idleCycles(5, 1'b1);

    $display("[TB] flush");
    sendFrame(ramp(40), tries);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, acc);
    sendFrame(ramp(60), tries);
    idleCycles(6, 1'b1);

    $display("[TB] async reset mid-frame");
    sendFrame(ramp(80), tries);
    idleCycles(2, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("arst_x_0", 32'(x_0), 32'(0));
    checkOutput("arst_x_1", 32'(x_1), 32'(0));
    checkOutput("arst_out_last", 32'(out_last), 32'(0));
    checkOutput("arst_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'(enable));
    idleCycles(2, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), random_frame(),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 19) != 0), acc);
    end
    idleCycles(PAIRS + 4, 1'b1);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
